pong_engine: RTL and testbench

PONG_ENGINE -- requirements
Module: pong_engine

---
 rtl/pong_engine.sv | 148 ++++++++++++++
 tb/tb_pong_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: two-paddle pong engine with tick-paced ball, scoring and serve/over states.
// Define PONG_SPEEDUP_EN to shorten the ball-step period on each paddle deflection.
module pong_engine #(
   parameter int TOTAL_WIDTH       = 640,
   parameter int TOTAL_HEIGHT      = 480,
   parameter int PADDLE_WIDTH      = 8,
   parameter int PADDLE_HEIGHT     = 64,
   parameter int BALL_SIZE         = 8,
   parameter int PADDLE_1_X        = 16,
   parameter int PADDLE_2_X        = 616,
   parameter int TICK_CLOCKS       = 100000,
   parameter int MIN_TICK_CLOCKS   = 25000,
   parameter int SPEEDUP_STEP      = 5000,
   parameter int WIN_SCORE         = 7,
   parameter int SERVE_DELAY_TICKS = 60,
   localparam int X_W = $clog2(TOTAL_WIDTH + 1),
   localparam int Y_W = $clog2(TOTAL_HEIGHT + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     move_1,
   input  logic [1:0]     move_2,
   output logic [Y_W-1:0] paddle_1_pos,
   output logic [Y_W-1:0] paddle_2_pos,
   output logic [X_W-1:0] ball_x,
   output logic [Y_W-1:0] ball_y,
   output logic [3:0]     score_1,
   output logic [3:0]     score_2,
   output logic [1:0]     state,
   output logic           winner,
   output logic           point_1,
   output logic           point_2
);
   localparam logic [1:0] IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3;
   localparam int PER_W = $clog2(TICK_CLOCKS + 1);
   localparam int SD_W = $clog2(SERVE_DELAY_TICKS + 1);
   localparam logic [X_W-1:0] CX = X_W'((TOTAL_WIDTH - BALL_SIZE) / 2);
   localparam logic [X_W-1:0] X_MAX = X_W'(TOTAL_WIDTH - BALL_SIZE);
   localparam logic [X_W-1:0] HIT_1 = X_W'(PADDLE_1_X + PADDLE_WIDTH);
   localparam logic [X_W-1:0] HIT_2 = X_W'(PADDLE_2_X - BALL_SIZE);
   localparam logic [Y_W-1:0] CY = Y_W'((TOTAL_HEIGHT - BALL_SIZE) / 2);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(TOTAL_HEIGHT - BALL_SIZE);
   localparam logic [Y_W-1:0] P_MAX = Y_W'(TOTAL_HEIGHT - PADDLE_HEIGHT);
   localparam logic [Y_W-1:0] P_INIT = Y_W'((TOTAL_HEIGHT - PADDLE_HEIGHT) / 2);
   localparam logic [Y_W:0] BS_E = (Y_W + 1)'(BALL_SIZE);
   localparam logic [Y_W:0] PH_E = (Y_W + 1)'(PADDLE_HEIGHT);
   localparam logic [PER_W-1:0] PER_INIT = PER_W'(TICK_CLOCKS);
   localparam logic [SD_W-1:0] SD_LAST = SD_W'(SERVE_DELAY_TICKS - 1);
   localparam logic [3:0] WIN = 4'(WIN_SCORE);

   logic [PER_W-1:0] cnt, cur_period;
   logic [SD_W-1:0] serve_cnt;
   logic dx, dy;
   logic [X_W-1:0] nx;
   logic [Y_W-1:0] ny;
   logic [3:0] s1_inc, s2_inc;
   logic run, tick, step, wall, hit_1, hit_2, pt_1, pt_2, won;
   logic [1:0] state_nxt;

   function automatic logic [Y_W-1:0] pad_step(input logic [Y_W-1:0] p, input logic [1:0] m);
      return (m == 2'b01 && p < P_MAX) ? p + 1'b1 : (m == 2'b11 && p != '0) ? p - 1'b1 : p;
   endfunction

   // dx/dy: 1 means moving right/down; pt_N means player N scores on this step
   always_comb begin
      run = state == SERVE || state == PLAY;
      tick = run && cnt == cur_period - 1'b1;
      step = state == PLAY && tick;
      nx = dx ? ball_x + 1'b1 : ball_x - 1'b1;
      ny = dy ? ball_y + 1'b1 : ball_y - 1'b1;
      wall = ny == '0 || ny == Y_MAX;
      hit_1 = !dx && nx == HIT_1 && {1'b0, ny} + BS_E > {1'b0, paddle_1_pos}
         && {1'b0, ny} < {1'b0, paddle_1_pos} + PH_E;
      hit_2 = dx && nx == HIT_2 && {1'b0, ny} + BS_E > {1'b0, paddle_2_pos}
         && {1'b0, ny} < {1'b0, paddle_2_pos} + PH_E;
      pt_1 = nx == X_MAX;
      pt_2 = nx == '0;
      s1_inc = score_1 + 1'b1;
      s2_inc = score_2 + 1'b1;
      won = (pt_1 && s1_inc == WIN) || (pt_2 && s2_inc == WIN);
      state_nxt = state == IDLE ? (start ? SERVE : IDLE)
         : state == SERVE ? ((tick && serve_cnt == SD_LAST) ? PLAY : SERVE)
         : state == PLAY ? ((step && (pt_1 || pt_2)) ? (won ? OVER : SERVE) : PLAY)
         : (start ? SERVE : OVER);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         score_1 <= '0;
         score_2 <= '0;
         winner <= 1'b0;
         point_1 <= 1'b0;
         point_2 <= 1'b0;
         paddle_1_pos <= P_INIT;
         paddle_2_pos <= P_INIT;
         ball_x <= CX;
         ball_y <= CY;
         dx <= 1'b0;
         dy <= 1'b0;
         cnt <= '0;
         serve_cnt <= '0;
      end else begin
         paddle_1_pos <= pad_step(paddle_1_pos, move_1);
         paddle_2_pos <= pad_step(paddle_2_pos, move_2);
         state <= state_nxt;
         cnt <= (!run || tick || state_nxt != state) ? '0 : cnt + 1'b1;
         serve_cnt <= (state != SERVE) ? '0 : serve_cnt + SD_W'(tick);
         point_1 <= step && pt_1;
         point_2 <= step && pt_2;
         if (state == OVER && start) begin
            score_1 <= '0;
            score_2 <= '0;
         end
         if (step) begin
            if (wall) dy <= !dy;
            if (pt_1 || pt_2) begin
               ball_x <= CX;
               ball_y <= CY;
               dx <= pt_1;
               if (pt_1) score_1 <= s1_inc;
               else score_2 <= s2_inc;
               if (won) winner <= pt_2;
            end else begin
               ball_x <= nx;
               ball_y <= ny;
               if (hit_1) dx <= 1'b1;
               if (hit_2) dx <= 1'b0;
            end
         end
      end
   end

`ifdef PONG_SPEEDUP_EN
   localparam logic [PER_W-1:0] PER_MIN = PER_W'(MIN_TICK_CLOCKS);
   localparam logic [PER_W-1:0] PER_STEP = PER_W'(SPEEDUP_STEP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cur_period <= PER_INIT;
      else if (state_nxt == SERVE && state != SERVE) cur_period <= PER_INIT;
      else if (step && !pt_1 && !pt_2 && (hit_1 || hit_2))
         cur_period <= ({1'b0, cur_period} > {1'b0, PER_MIN} + {1'b0, PER_STEP}) ? cur_period - PER_STEP : PER_MIN;
   end
`else
   assign cur_period = PER_INIT;
`endif
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed self-checking bench for pong_engine on a 64x48 field.
module tb_pong_engine;
   localparam int X_W = 7, Y_W = 6;
`ifdef PONG_SPEEDUP_EN
   localparam int INT_1 = 3, INT_2 = 2;
`else
   localparam int INT_1 = 4, INT_2 = 4;
`endif
   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [1:0] move_1 = 2'b00, move_2 = 2'b00;
   logic [Y_W-1:0] paddle_1_pos, paddle_2_pos, ball_y;
   logic [X_W-1:0] ball_x;
   logic [3:0] score_1, score_2;
   logic [1:0] state;
   logic winner, point_1, point_2;
   int n_run = 0, n_fail = 0;

   typedef struct {
      logic [1:0] m1;
      logic [1:0] m2;
      int n;
      int p1;
      int p2;
   } vec_t;
   vec_t vecs[6];

   pong_engine #(
      .TOTAL_WIDTH(64), .TOTAL_HEIGHT(48), .PADDLE_WIDTH(2), .PADDLE_HEIGHT(8),
      .BALL_SIZE(2), .PADDLE_1_X(2), .PADDLE_2_X(60), .TICK_CLOCKS(4),
      .MIN_TICK_CLOCKS(2), .SPEEDUP_STEP(1), .WIN_SCORE(3), .SERVE_DELAY_TICKS(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .move_1(move_1), .move_2(move_2),
      .paddle_1_pos(paddle_1_pos), .paddle_2_pos(paddle_2_pos),
      .ball_x(ball_x), .ball_y(ball_y), .score_1(score_1), .score_2(score_2),
      .state(state), .winner(winner), .point_1(point_1), .point_2(point_2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " state"}, state, 0);
      chk({tag, " ball_x"}, ball_x, 31);
      chk({tag, " ball_y"}, ball_y, 23);
      chk({tag, " paddle_1"}, paddle_1_pos, 20);
      chk({tag, " paddle_2"}, paddle_2_pos, 20);
      chk({tag, " score_1"}, score_1, 0);
      chk({tag, " score_2"}, score_2, 0);
      chk({tag, " winner"}, winner, 0);
      chk({tag, " point_1"}, point_1, 0);
      chk({tag, " point_2"}, point_2, 0);
   endtask

   task automatic wait_point_2(input string tag);
      int n = 0;
      while (point_2 !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " point_2 seen"}, n < 2000, 1);
   endtask

   initial begin
      int n;
      vecs[0] = '{2'b01, 2'b00, 40, 40, 20};
      vecs[1] = '{2'b11, 2'b01, 50, 0, 40};
      vecs[2] = '{2'b10, 2'b10, 5, 0, 40};
      vecs[3] = '{2'b00, 2'b11, 18, 0, 22};
      vecs[4] = '{2'b01, 2'b01, 2, 2, 24};
      vecs[5] = '{2'b10, 2'b01, 3, 2, 27};
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (100) @(negedge clk);
      chk_reset_vals("idle");
      for (int i = 0; i < 6; i++) begin
         move_1 = vecs[i].m1;
         move_2 = vecs[i].m2;
         repeat (vecs[i].n) @(negedge clk);
         chk($sformatf("vec%0d paddle_1", i), paddle_1_pos, vecs[i].p1);
         chk($sformatf("vec%0d paddle_2", i), paddle_2_pos, vecs[i].p2);
         chk($sformatf("vec%0d state", i), state, 0);
         chk($sformatf("vec%0d ball_x", i), ball_x, 31);
      end
      move_1 = 2'b00;
      move_2 = 2'b00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("serve entered", state, 1);
      n = 0;
      while (state != 2'd2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("serve to play clocks", n, 8);
      n = 0;
      while (ball_x != 7'd4 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reach left paddle", n < 2000, 1);
      chk("left hit ball_y", ball_y, 4);
      n = 0;
      while (ball_x == 7'd4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("period after left hit", n, INT_1);
      chk("moving right", ball_x, 5);
      n = 0;
      while (ball_x != 7'd58 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reach right paddle", n < 2000, 1);
      chk("right hit ball_y", ball_y, 34);
      n = 0;
      while (ball_x == 7'd58 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("period after right hit", n, INT_2);
      chk("moving left", ball_x, 57);
      wait_point_2("r1");
      chk("r1 score_2", score_2, 1);
      chk("r1 score_1", score_1, 0);
      chk("r1 ball_x", ball_x, 31);
      chk("r1 ball_y", ball_y, 23);
      chk("r1 state", state, 1);
      @(negedge clk);
      chk("r1 pulse one cycle", point_2, 0);
      move_1 = 2'b01;
      repeat (18) @(negedge clk);
      move_1 = 2'b00;
      chk("paddle_1 moved away", paddle_1_pos, 20);
      wait_point_2("r2");
      chk("r2 score_2", score_2, 2);
      chk("r2 state", state, 1);
      @(negedge clk);
      wait_point_2("r3");
      chk("r3 score_2", score_2, 3);
      chk("r3 score_1", score_1, 0);
      chk("r3 state", state, 3);
      chk("r3 winner", winner, 1);
      repeat (20) @(negedge clk);
      chk("over held state", state, 3);
      chk("over held score", score_2, 3);
      chk("over ball_x", ball_x, 31);
      chk("over ball_y", ball_y, 23);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart state", state, 1);
      chk("restart score_1", score_1, 0);
      chk("restart score_2", score_2, 0);
      n = 0;
      while (state != 2'd2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("replay reached", n < 100, 1);
      repeat (10) @(negedge clk);
      chk("mid play state", state, 2);
      chk("mid play ball_x", ball_x, 29);
      chk("mid play paddle_2", paddle_2_pos, 27);
      #3 rst = 1'b0;
      #1 chk_reset_vals("async rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("after rst release state", state, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
